tree_ser: RTL and testbench

TREE_SER -- requirements
Module: tree_ser

---
 rtl/tree_ser_if.sv | 11 +
 rtl/tree_ser.sv | 149 ++++++++++++++
 tb/tb_tree_ser.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/tree_ser_if.sv
// Parallel word handshake into the serializer.
interface tree_ser_if #(
  parameter int unsigned W = 4
) ();
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/tree_ser.sv
// Serializer: 2-entry word FIFO feeding an LSB-first bit stream, one marker
// bit after each reset release, sticky underflow when a burst starves.
`ifndef SERDES_STAGES
`define SERDES_STAGES 2
`endif

module tree_ser #(
  parameter int unsigned STAGES = `SERDES_STAGES
) (
  input  logic        clk,
  input  logic        rstb,
  tree_ser_if.slave   bus,
  output logic        dout,
  output logic        dout_valid,
  output logic        word_start,
  output logic        underflow
);

  localparam int unsigned W = 1 << STAGES;
  localparam int unsigned DEPTH = 2;

  typedef enum logic [1:0] {IDLE, MARK, SHIFT} state_t;

  state_t              state, state_nxt;
  logic [W-1:0]        mem [DEPTH];
  logic                rd_ptr, wr_ptr;
  logic [1:0]          count, count_nxt;
  logic [W-1:0]        shreg, shreg_nxt;
  logic [STAGES-1:0]   bitcnt, bitcnt_nxt;
  logic                marker_sent, marker_nxt;
  logic                underflow_nxt;
  logic                load;
  logic                push;
  logic                dout_nxt, dout_valid_nxt, word_start_nxt;

  // Accept only against the registered ready, so valid never feeds ready.
  assign push = bus.din_valid && bus.din_ready;

  // FIFO occupancy after this edge; a load pops using pre-edge contents.
  always_comb begin
    count_nxt = count;
    case ({push, load})
      2'b10:   count_nxt = 2'(count + 2'd1);
      2'b01:   count_nxt = 2'(count - 2'd1);
      default: count_nxt = count;
    endcase
  end

  // Next-state, shift-register load and registered output values.
  always_comb begin
    state_nxt      = state;
    load           = 1'b0;
    shreg_nxt      = shreg;
    bitcnt_nxt     = bitcnt;
    marker_nxt     = marker_sent;
    underflow_nxt  = underflow;
    dout_nxt       = 1'b0;
    dout_valid_nxt = 1'b0;
    word_start_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (count != 2'd0) begin
          if (!marker_sent) begin
            state_nxt  = MARK;
            marker_nxt = 1'b1;
          end else begin
            state_nxt = SHIFT;
            load      = 1'b1;
          end
        end
      end
      MARK: begin
        if (count != 2'd0) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        bitcnt_nxt = STAGES'(bitcnt + 1'b1);
        if (bitcnt == STAGES'(W - 1)) begin
          if (count != 2'd0) begin
            load = 1'b1;
          end else begin
            state_nxt     = IDLE;
            underflow_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      shreg_nxt  = mem[rd_ptr];
      bitcnt_nxt = '0;
    end

    case (state_nxt)
      MARK: begin
        dout_nxt       = 1'b1;
        dout_valid_nxt = 1'b1;
      end
      SHIFT: begin
        dout_nxt       = shreg_nxt[bitcnt_nxt];
        dout_valid_nxt = 1'b1;
        word_start_nxt = (bitcnt_nxt == '0);
      end
      default: ;
    endcase
  end

  // State, FIFO storage and registered outputs; reset clears everything.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state         <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
      shreg         <= '0;
      bitcnt        <= '0;
      marker_sent   <= 1'b0;
      underflow     <= 1'b0;
      dout          <= 1'b0;
      dout_valid    <= 1'b0;
      word_start    <= 1'b0;
      bus.din_ready <= 1'b0;
    end else begin
      state       <= state_nxt;
      if (push) begin
        mem[wr_ptr] <= bus.din;
        wr_ptr      <= ~wr_ptr;
      end
      if (load) rd_ptr <= ~rd_ptr;
      count         <= count_nxt;
      shreg         <= shreg_nxt;
      bitcnt        <= bitcnt_nxt;
      marker_sent   <= marker_nxt;
      underflow     <= underflow_nxt;
      dout          <= dout_nxt;
      dout_valid    <= dout_valid_nxt;
      word_start    <= word_start_nxt;
      bus.din_ready <= (count_nxt < 2'(DEPTH));
    end
  end

endmodule

// File: tb/tb_tree_ser.sv
// Directed bench for tree_ser with STAGES=2 (4-bit words).
module tb_tree_ser;

  localparam int unsigned STAGES = 2;
  localparam int unsigned W = 4;

  logic clk  = 1'b0;
  logic rstb = 1'b1;
  logic dout, dout_valid, word_start, underflow;

  tree_ser_if #(.W(W)) bus ();

  tree_ser #(.STAGES(STAGES)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .bus        (bus),
    .dout       (dout),
    .dout_valid (dout_valid),
    .word_start (word_start),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] cap_bits, cap_ws;
  int          n_valid, first_idx, last_idx, n_stall;
  logic        uf_during;
  logic [W-1:0] q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Offer queued words back to back while capturing the serial stream.
  task automatic run(input logic [W-1:0] words[$], input int ncyc);
    logic rdy;
    cap_bits  = '0;
    cap_ws    = '0;
    n_valid   = 0;
    first_idx = -1;
    last_idx  = -1;
    n_stall   = 0;
    uf_during = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (words.size() > 0) begin
        bus.din       = words[0];
        bus.din_valid = 1'b1;
      end else begin
        bus.din       = '0;
        bus.din_valid = 1'b0;
      end
      rdy = bus.din_ready;
      if (bus.din_valid && !rdy) n_stall++;
      tick();
      if (bus.din_valid && rdy) void'(words.pop_front());
      if (dout_valid === 1'b1) begin
        if (n_valid < 32) begin
          cap_bits[n_valid] = dout;
          cap_ws[n_valid]   = word_start;
        end
        if (first_idx < 0) first_idx = i;
        last_idx  = i;
        n_valid++;
        uf_during = uf_during | underflow;
      end
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstb          = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    tick();
    tick();
    rstb = 1'b1;
  endtask

  initial begin
    bus.din       = '0;
    bus.din_valid = 1'b0;

    // Asynchronous reset takes effect without a clock edge.
    #2 rstb = 1'b0;
    #1;
    chk("rst_dout",       32'(dout),          32'h0);
    chk("rst_dout_valid", 32'(dout_valid),    32'h0);
    chk("rst_word_start", 32'(word_start),    32'h0);
    chk("rst_underflow",  32'(underflow),     32'h0);
    chk("rst_din_ready",  32'(bus.din_ready), 32'h0);
    tick();
    tick();
    rstb = 1'b1;
    chk("ready_before_edge", 32'(bus.din_ready), 32'h0);
    tick();
    chk("ready_after_edge",  32'(bus.din_ready), 32'h1);

    // Single word 1010: marker then 0,1,0,1.
    q = {4'hA};
    run(q, 12);
    chk("a_bits",       cap_bits,                      32'h15);
    chk("a_nvalid",     32'(n_valid),                  32'd5);
    chk("a_ws",         cap_ws,                        32'h02);
    chk("a_first",      32'(first_idx),                32'd1);
    chk("a_contig",     32'(last_idx - first_idx + 1), 32'd5);
    chk("a_uf_during",  32'(uf_during),                32'h0);
    chk("a_uf_after",   32'(underflow),                32'h1);
    chk("a_idle_valid", 32'(dout_valid),               32'h0);

    // Marker already sent: bit 0 appears one edge after the transfer.
    q = {4'h5};
    run(q, 10);
    chk("lat_first",  32'(first_idx), 32'd1);
    chk("lat_nvalid", 32'(n_valid),   32'd4);
    chk("lat_bits",   cap_bits,       32'h5);
    chk("lat_ws",     cap_ws,         32'h1);
    chk("lat_uf",     32'(underflow), 32'h1);

    // Three words back to back: contiguous 13-bit burst.
    do_reset();
    tick();
    q = {4'hA, 4'h3, 4'hF};
    run(q, 25);
    chk("b_bits",      cap_bits,                      32'h1E75);
    chk("b_nvalid",    32'(n_valid),                  32'd13);
    chk("b_ws",        cap_ws,                        32'h222);
    chk("b_contig",    32'(last_idx - first_idx + 1), 32'd13);
    chk("b_uf_during", 32'(uf_during),                32'h0);
    chk("b_uf_after",  32'(underflow),                32'h1);

    // Backpressure with a full FIFO: no word lost or duplicated.
    do_reset();
    tick();
    q = {4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    run(q, 35);
    chk("c_bits",   cap_bits,                      32'hA8643);
    chk("c_nvalid", 32'(n_valid),                  32'd21);
    chk("c_contig", 32'(last_idx - first_idx + 1), 32'd21);
    chk("c_stalls", 32'(n_stall),                  32'd7);
    chk("c_uf",     32'(underflow),                32'h1);

    // Reset during bit 2 of 0110, then a fresh stream with marker.
    do_reset();
    tick();
    q = {4'h6};
    run(q, 5);
    chk("d_partial_bits", cap_bits,        32'hD);
    chk("d_bit2",         32'(dout),       32'h1);
    rstb = 1'b0;
    #1;
    chk("d_rst_dout",   32'(dout),          32'h0);
    chk("d_rst_valid",  32'(dout_valid),    32'h0);
    chk("d_rst_ws",     32'(word_start),    32'h0);
    chk("d_rst_ready",  32'(bus.din_ready), 32'h0);
    chk("d_rst_uf",     32'(underflow),     32'h0);
    tick();
    rstb = 1'b1;
    tick();
    q = {4'h9};
    run(q, 12);
    chk("d_bits",   cap_bits,       32'h13);
    chk("d_nvalid", 32'(n_valid),   32'd5);
    chk("d_ws",     cap_ws,         32'h02);
    chk("d_first",  32'(first_idx), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
